// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES GF(2^8) helpers, state widths and MixColumns FSM states
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;

  // First row of each circulant matrix, coefficient k at [k*BYTE_W +: BYTE_W]
  localparam logic [COL_W-1:0] FWD_COEF = 32'h01010302;
  localparam logic [COL_W-1:0] INV_COEF = 32'h090d0b0e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mc_state_e;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul09(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul0b(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul0d(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul0e(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Only the seven coefficients used by MixColumns / InvMixColumns are needed
  function automatic logic [BYTE_W-1:0] gf_mul_coef(input logic [BYTE_W-1:0] a,
                                                     input logic [BYTE_W-1:0] c);
    case (c)
      8'h01:   return a;
      8'h02:   return xtime(a);
      8'h03:   return xtime(a) ^ a;
      8'h09:   return gf_mul09(a);
      8'h0b:   return gf_mul0b(a);
      8'h0d:   return gf_mul0d(a);
      8'h0e:   return gf_mul0e(a);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// rtl/mix_column_word.sv - combinational forward/inverse MixColumns on one 32-bit column
module mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             inv,
  output logic [COL_W-1:0] col_out
);

  logic [COL_W-1:0] fwd_col;
  logic [COL_W-1:0] inv_col;

  // Row r of a circulant matrix: out[r] = sum_k coef[k] * in[(r+k) mod 4]
  always_comb begin
    fwd_col = '0;
    inv_col = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        fwd_col[r*BYTE_W +: BYTE_W] = fwd_col[r*BYTE_W +: BYTE_W]
          ^ gf_mul_coef(col_in[((r + k) % 4)*BYTE_W +: BYTE_W], FWD_COEF[k*BYTE_W +: BYTE_W]);
        inv_col[r*BYTE_W +: BYTE_W] = inv_col[r*BYTE_W +: BYTE_W]
          ^ gf_mul_coef(col_in[((r + k) % 4)*BYTE_W +: BYTE_W], INV_COEF[k*BYTE_W +: BYTE_W]);
      end
    end
  end

  assign col_out = inv ? inv_col : fwd_col;

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - iterative handshaked AES MixColumns/InvMixColumns engine
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               inv,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);

  localparam int         NUM_STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e          state_q, state_d;
  logic [1:0]         step_q;
  logic               inv_q;
  logic [STATE_W-1:0] work_q, work_d;
  logic               accept;

  logic [1:0]         col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = 2'(int'(step_q) * COLS_PER_CYCLE + k);
    assign col_in[k]  = work_q[col_idx[k]*COL_W +: COL_W];

    mix_column_word u_mix (
      .col_in  (col_in[k]),
      .inv     (inv_q),
      .col_out (col_out[k])
    );
  end

  // Only the columns of the current step are replaced; the rest pass through
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_d[col_idx[k]*COL_W +: COL_W] = col_out[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (step_q == LAST_STEP) state_d = ST_DONE;
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? ST_BUSY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
  // Gate so a half-transformed working register never reaches the output
  assign state_out = out_valid ? work_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      inv_q  <= 1'b0;
      step_q <= '0;
    end else if (accept) begin
      work_q <= state_in;
      inv_q  <= inv;
      step_q <= '0;
    end else if (state_q == ST_BUSY) begin
      work_q <= work_d;
      step_q <= (step_q == LAST_STEP) ? 2'd0 : step_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - randomized self-checking bench for mix_columns_seq, all COLS_PER_CYCLE values
module tb_mix_columns_seq;

  localparam logic [127:0] T1_IN  = 128'hc6c6c6c6_01010101_5c220af2_455313db;
  localparam logic [127:0] T1_OUT = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] T3_IN  = {32'h4c31262d, 32'hd5d4d4d4, 64'h0};
  localparam logic [127:0] T3_OUT = {32'hf8bd7e4d, 32'hd6d7d5d5, 64'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         inv       [3];
  logic [127:0] state_in  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];
  logic         busy      [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .inv       (inv[g]),
      .state_in  (state_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: polynomial product then reduction by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s, input logic m);
    logic [7:0]   row0 [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (m) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else   row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(row0[(j - rr + 4) % 4], s[c*32 + j*8 +: 8]);
        r[c*32 + rr*8 +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int d, input logic [127:0] s, input logic m);
    int n = 0;
    while (!in_ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 128'(in_ready[d]), 128'(1));
    state_in[d] = s;
    inv[d]      = m;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic collect(input int d, input bit toggle, output logic [127:0] res);
    int n = 0;
    while (!out_valid[d] && n < 20) begin
      if (toggle) inv[d] = ~inv[d];
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency_cpc%0d", 1 << d), 128'(n), 128'(4 >> d));
    res = state_out[d];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] res, res2, s, s2, held;
    logic         m;
    int           n;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      inv[d]       = 1'b0;
      out_ready[d] = 1'b1;
      state_in[d]  = '0;
    end
    #2;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready",  128'(in_ready[d]),  128'(1));
      check("rst_out_valid", 128'(out_valid[d]), 128'(0));
      check("rst_busy",      128'(busy[d]),      128'(0));
      check("rst_state_out", state_out[d],       128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vector forward, then inverse round trip
    for (int d = 0; d < 3; d++) begin
      send(d, T1_IN, 1'b0);
      collect(d, 1'b0, res);
      check("t1_fwd", res, T1_OUT);
      send(d, res, 1'b1);
      collect(d, 1'b0, res2);
      check("t2_roundtrip", res2, T1_IN);
    end

    send(0, T3_IN, 1'b0);
    collect(0, 1'b0, res);
    check("t3_cols", res, T3_OUT);
    check("t3_zero_cols", 128'(res[63:0]), 128'(0));

    // Backpressure hold, then back-to-back accept on release
    s = rand128();
    send(0, s, 1'b0);
    out_ready[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    held = state_out[0];
    check("bp_result", held, model_mix(s, 1'b0));
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = (i % 2 == 0);
      state_in[0] = rand128();
      inv[0]      = 1'($urandom);
      @(posedge clk); #1;
      check("bp_hold",     state_out[0],         held);
      check("bp_valid",    128'(out_valid[0]),   128'(1));
      check("bp_in_ready", 128'(in_ready[0]),    128'(0));
    end
    s2 = rand128();
    state_in[0]  = s2;
    inv[0]       = 1'b1;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    check("bp_release_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("bp_b2b_busy",  128'(busy[0]),      128'(1));
    check("bp_b2b_valid", 128'(out_valid[0]), 128'(0));
    collect(0, 1'b0, res);
    check("bp_second", res, model_mix(s2, 1'b1));

    // Asynchronous reset at step 2 of 4
    s = rand128();
    send(0, s, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid[0]), 128'(0));
    check("arst_state_out", state_out[0],       128'(0));
    check("arst_in_ready",  128'(in_ready[0]),  128'(1));
    check("arst_busy",      128'(busy[0]),      128'(0));
    #2;
    rst_n = 1'b1;
    s2 = rand128();
    send(0, s2, 1'b1);
    collect(0, 1'b0, res);
    check("arst_next", res, model_mix(s2, 1'b1));

    // inv toggling while BUSY must not affect the latched mode
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        s = rand128();
        m = 1'($urandom);
        send(d, s, m);
        collect(d, 1'b1, res);
        check("mode_stable", res, model_mix(s, m));
      end
    end

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        s = rand128();
        send(d, s, 1'b0);
        collect(d, 1'b0, res);
        check("rnd_fwd", res, model_mix(s, 1'b0));
        send(d, res, 1'b1);
        collect(d, 1'b0, res2);
        check("rnd_identity", res2, s);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
